// File: rtl/serial_word_collector.sv
// serial_word_collector
//   Assembles an N-bit word from a framed serial bit stream and hands it to
//   the difference-counter stage over a valid/ready handshake. A shift
//   register collects the frame in progress while a separate holding
//   register (word_out) keeps the previous word until it is consumed.
//
//   Parameters
//     N          data bits per frame (2..16)
//     LSB_FIRST  1: first received bit -> word_out[0]; 0: -> word_out[N-1]
//
//   Optional feature (macro PARITY_CHECK_EN)
//     When defined, one even-parity bit follows the N data bits and par_err
//     is loaded together with word_out. When undefined, par_err is tied to 0.
//
//   Ports
//     clk, rst_n            clock, synchronous active-low reset
//     bit_in, bit_valid     serial bit and its qualifier
//     frame_start           marks a valid bit as bit 0 of a new frame
//     word_out, word_valid  assembled word / holds an unconsumed word
//     word_ready            consumer accepts when word_valid && word_ready
//     busy                  a frame is in progress
//     overrun, clr_ovr      sticky dropped-word flag and its clear
//     par_err               parity error for the word in word_out
module serial_word_collector #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bit_in,
  input  logic         bit_valid,
  input  logic         frame_start,
  output logic [N-1:0] word_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         busy,
  output logic         overrun,
  input  logic         clr_ovr,
  output logic         par_err
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef PARITY_CHECK_EN
    PARITY = 2'd2,
`endif
    SHIFT  = 2'd1
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   sreg, sreg_ins, mask, word_nxt;
  logic           start, dbit, done, load;
  logic [CW-1:0]  pos;

  // A frame_start bit restarts the frame from any state.
  assign start = bit_valid && frame_start;

  // Data bit accepted into the shift register this cycle.
  assign dbit  = start || (state == SHIFT && bit_valid);

  // Position of the incoming bit; a restart always writes position 0.
  assign pos   = start ? '0 : cnt;

  // One-hot write mask keeps the index arithmetic width-clean.
  assign mask  = LSB_FIRST ? ({{(N-1){1'b0}}, 1'b1} << pos)
                           : ({1'b1, {(N-1){1'b0}}} >> pos);

  always_comb begin
    sreg_ins = start ? '0 : sreg;
    sreg_ins = (sreg_ins & ~mask) | ({N{bit_in}} & mask);
  end

`ifdef PARITY_CHECK_EN
  logic perr;
  // Completion is the parity bit; the data is already in sreg.
  assign done     = (state == PARITY) && bit_valid && !frame_start;
  assign word_nxt = sreg;
  assign perr     = (^sreg) ^ bit_in;
`else
  assign done     = (state == SHIFT) && bit_valid && !frame_start &&
                    (cnt == CW'(N - 1));
  assign word_nxt = sreg_ins;
`endif

  // A completed word only replaces word_out when the slot is free or
  // being emptied on this same edge; otherwise it is dropped.
  assign load = done && (!word_valid || word_ready);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = SHIFT;
      SHIFT: begin
        if (start) state_nxt = SHIFT;
        else if (bit_valid && cnt == CW'(N - 1))
`ifdef PARITY_CHECK_EN
          state_nxt = PARITY;
`else
          state_nxt = IDLE;
`endif
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (start)          state_nxt = SHIFT;
        else if (bit_valid) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Frame datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      sreg <= '0;
    end else if (dbit) begin
      cnt  <= start ? CW'(1) : cnt + CW'(1);
      sreg <= sreg_ins;
    end
  end

  // Holding register, handshake and overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        word_out   <= word_nxt;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      // Set wins over a simultaneous clear.
      if (done && !load) overrun <= 1'b1;
      else if (clr_ovr)  overrun <= 1'b0;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)    par_err <= 1'b0;
    else if (load) par_err <= perr;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule
